// File: rtl/mac_acc_pkg.sv
// Shared types and default sizing for the MAC accumulate stage.
// Saturating accumulation is selected by defining MAC_ACC_SAT_EN.
package mac_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int DEF_PROD_W    = 8;
    localparam int DEF_ACC_W     = 16;
    localparam int DEF_MAX_BEATS = 4;
    localparam int DEF_CNT_W     = $clog2(DEF_MAX_BEATS + 1);

    // All-ones accumulator value used when saturation is enabled.
    localparam logic [DEF_ACC_W-1:0] DEF_SAT_VAL = {DEF_ACC_W{1'b1}};

endpackage

// File: rtl/mac_accum_stage_if.sv
// Product-in / group-result-out handshake bundle for mac_accum_stage.
interface mac_accum_stage_if
    import mac_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_ovf
    );
endinterface

// File: rtl/accum_add.sv
// Combinational accumulator adder: acc + zero-extended product, with carry-out.
module accum_add #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, ACC_W'(prod)};
endmodule

// File: rtl/mac_accum_stage.sv
// Accumulates product beats into groups closed by in_last or MAX_BEATS, then holds the result.
// Define MAC_ACC_SAT_EN to saturate the sum on overflow instead of wrapping.
module mac_accum_stage
    import mac_acc_pkg::*;
#(
    parameter int PROD_W    = DEF_PROD_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int MAX_BEATS = DEF_MAX_BEATS
) (
    input  logic               clk,
    input  logic               rst_n,
    mac_accum_stage_if.slave   io
);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

`ifdef MAC_ACC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_SAT = {ACC_W{1'b1}};
`endif

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic               accept;
    logic               close;
    logic [ACC_W-1:0]   add_a;
    logic [ACC_W-1:0]   sum;
    logic               carry;

    assign io.in_ready  = (state_q != HOLD);
    assign io.out_valid = (state_q == HOLD);
    assign io.out_acc   = acc_q;
    assign io.out_count = cnt_q;
    assign io.out_ovf   = ovf_q;

    assign accept = io.in_valid && io.in_ready;
    // First beat of a group always starts from zero.
    assign add_a  = (state_q == IDLE) ? '0 : acc_q;

    accum_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .a    (add_a),
        .prod (io.in_prod),
        .sum  (sum),
        .cout (carry)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        close   = 1'b0;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
`ifdef MAC_ACC_SAT_EN
                    // Once pinned at all-ones, any further nonzero beat carries again.
                    acc_d = carry ? ACC_SAT : sum;
`else
                    acc_d = sum;
`endif
                    cnt_d   = cnt_q + CNT_W'(1);
                    ovf_d   = ovf_q | carry;
                    close   = io.in_last || (cnt_q == CNT_W'(MAX_BEATS - 1));
                    state_d = close ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mac_accum_stage.sv
// Scoreboard bench for mac_accum_stage: default config plus a narrow overflow config.
module tb_mac_accum_stage;
    import mac_acc_pkg::*;

    localparam int A_ACC_W = 16;
    localparam int A_MAX   = 4;
    localparam int A_CNT_W = $clog2(A_MAX + 1);
    localparam int B_ACC_W = 10;
    localparam int B_MAX   = 8;
    localparam int B_CNT_W = $clog2(B_MAX + 1);

    typedef struct {
        int acc;
        int cnt;
        int ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_accum_stage_if #(.PROD_W(8), .ACC_W(A_ACC_W), .CNT_W(A_CNT_W)) ia ();
    mac_accum_stage_if #(.PROD_W(8), .ACC_W(B_ACC_W), .CNT_W(B_CNT_W)) ib ();

    mac_accum_stage #(.PROD_W(8), .ACC_W(A_ACC_W), .MAX_BEATS(A_MAX)) u_a (
        .clk (clk), .rst_n (rst_n), .io (ia)
    );
    mac_accum_stage #(.PROD_W(8), .ACC_W(B_ACC_W), .MAX_BEATS(B_MAX)) u_b (
        .clk (clk), .rst_n (rst_n), .io (ib)
    );

    res_t qa[$];
    res_t qb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   a_sum = 0, a_cnt = 0, b_sum = 0, b_cnt = 0;
    bit   a_done;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    // Reference: a group result depends only on the total of its beats.
    function automatic res_t ref_group(input int sum, input int cnt, input int acc_w);
        res_t r;
        int lim;
        lim   = 1 << acc_w;
        r.cnt = cnt;
        r.ovf = (sum >= lim) ? 1 : 0;
`ifdef MAC_ACC_SAT_EN
        r.acc = r.ovf ? lim - 1 : sum;
`else
        r.acc = sum % lim;
`endif
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && ia.out_valid && ia.out_ready) begin
            if (qa.size() == 0) chk("a_result_expected", qa.size(), 1);
            else begin
                res_t e;
                e = qa.pop_front();
                chk("a_acc", int'(ia.out_acc), e.acc);
                chk("a_count", int'(ia.out_count), e.cnt);
                chk("a_ovf", int'(ia.out_ovf), e.ovf);
            end
        end
        if (rst_n && ib.out_valid && ib.out_ready) begin
            if (qb.size() == 0) chk("b_result_expected", qb.size(), 1);
            else begin
                res_t e;
                e = qb.pop_front();
                chk("b_acc", int'(ib.out_acc), e.acc);
                chk("b_count", int'(ib.out_count), e.cnt);
                chk("b_ovf", int'(ib.out_ovf), e.ovf);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_a(input int p, input bit last);
        int w = 0;
        ia.in_valid = 1'b1;
        ia.in_prod  = 8'(p);
        ia.in_last  = last;
        @(negedge clk);
        while (!ia.in_ready && w < 100) begin w++; @(negedge clk); end
        if (!ia.in_ready) begin
            chk("a_send_timeout", int'(ia.in_ready), 1);
            ia.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        ia.in_valid = 1'b0;
        a_sum += p; a_cnt++;
        if (last || a_cnt == A_MAX) begin
            qa.push_back(ref_group(a_sum, a_cnt, A_ACC_W));
            a_sum = 0; a_cnt = 0;
        end
    endtask

    task automatic send_b(input int p, input bit last);
        int w = 0;
        ib.in_valid = 1'b1;
        ib.in_prod  = 8'(p);
        ib.in_last  = last;
        @(negedge clk);
        while (!ib.in_ready && w < 100) begin w++; @(negedge clk); end
        if (!ib.in_ready) begin
            chk("b_send_timeout", int'(ib.in_ready), 1);
            ib.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        ib.in_valid = 1'b0;
        b_sum += p; b_cnt++;
        if (last || b_cnt == B_MAX) begin
            qb.push_back(ref_group(b_sum, b_cnt, B_ACC_W));
            b_sum = 0; b_cnt = 0;
        end
    endtask

    task automatic release_a();
        ia.out_ready = 1'b1;
        @(posedge clk); #1;
        ia.out_ready = 1'b0;
    endtask

    task automatic release_b();
        ib.out_ready = 1'b1;
        @(posedge clk); #1;
        ib.out_ready = 1'b0;
    endtask

    initial begin
        ia.in_valid = 0; ia.in_prod = 0; ia.in_last = 0; ia.out_ready = 0;
        ib.in_valid = 0; ib.in_prod = 0; ib.in_last = 0; ib.out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(ia.in_ready), 1);
        chk("rst_out_valid", int'(ia.out_valid), 0);
        chk("rst_out_acc", int'(ia.out_acc), 0);
        chk("rst_out_count", int'(ia.out_count), 0);
        chk("rst_out_ovf", int'(ia.out_ovf), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Close on MAX_BEATS
        repeat (3) send_a(225, 1'b0);
        chk("max_pre_valid", int'(ia.out_valid), 0);
        chk("max_pre_count", int'(ia.out_count), 3);
        send_a(225, 1'b0);
        chk("max_valid", int'(ia.out_valid), 1);
        chk("max_in_ready", int'(ia.in_ready), 0);
        chk("max_acc", int'(ia.out_acc), 900);
        chk("max_count", int'(ia.out_count), 4);
        release_a();
        chk("max_post_in_ready", int'(ia.in_ready), 1);

        // Close on in_last, then backpressure with beats offered during HOLD
        send_a(10, 1'b0);
        send_a(20, 1'b1);
        chk("last_valid", int'(ia.out_valid), 1);
        chk("last_in_ready", int'(ia.in_ready), 0);
        chk("last_acc", int'(ia.out_acc), 30);
        ia.in_valid = 1'b1; ia.in_prod = 8'd99; ia.in_last = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_valid", int'(ia.out_valid), 1);
            chk("bp_acc", int'(ia.out_acc), 30);
            chk("bp_count", int'(ia.out_count), 2);
            chk("bp_in_ready", int'(ia.in_ready), 0);
        end
        ia.out_ready = 1'b1;
        @(posedge clk); #1;
        ia.out_ready = 1'b0;
        chk("bp_rel_in_ready", int'(ia.in_ready), 1);
        chk("bp_rel_valid", int'(ia.out_valid), 0);
        chk("bp_no_bypass_count", int'(ia.out_count), 0);
        ia.in_valid = 1'b0;
        @(posedge clk); #1;

        // Zero-valued single beat
        send_a(0, 1'b1);
        chk("zero_valid", int'(ia.out_valid), 1);
        chk("zero_acc", int'(ia.out_acc), 0);
        chk("zero_count", int'(ia.out_count), 1);
        release_a();

        // Reset mid-group discards the partial sum
        send_a(5, 1'b0);
        send_a(7, 1'b0);
        chk("part_acc", int'(ia.out_acc), 12);
        rst_n = 1'b0;
        #1;
        chk("midrst_acc", int'(ia.out_acc), 0);
        chk("midrst_count", int'(ia.out_count), 0);
        chk("midrst_valid", int'(ia.out_valid), 0);
        chk("midrst_ovf", int'(ia.out_ovf), 0);
        chk("midrst_in_ready", int'(ia.in_ready), 1);
        a_sum = 0; a_cnt = 0; b_sum = 0; b_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_a(3, 1'b1);
        chk("after_rst_acc", int'(ia.out_acc), 3);
        chk("after_rst_count", int'(ia.out_count), 1);
        release_a();

        // Narrow accumulator overflow: 8 x 225 = 1800
        repeat (8) send_b(225, 1'b0);
        chk("ovf_valid", int'(ib.out_valid), 1);
        chk("ovf_count", int'(ib.out_count), 8);
        chk("ovf_flag", int'(ib.out_ovf), 1);
`ifdef MAC_ACC_SAT_EN
        chk("ovf_acc", int'(ib.out_acc), 1023);
`else
        chk("ovf_acc", int'(ib.out_acc), 776);
`endif
        release_b();

        // Random groups with random consumer backpressure
        a_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 120; i++) begin
                    send_a($urandom_range(0, 255), ($urandom_range(0, 3) == 0));
                    if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
                end
                if (a_cnt != 0) send_a($urandom_range(0, 255), 1'b1);
                a_done = 1'b1;
            end
            begin
                while (!a_done) begin
                    @(posedge clk); #1;
                    ia.out_ready = ($urandom_range(0, 1) == 1);
                end
                ia.out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        ia.out_ready = 1'b0;

        ib.out_ready = 1'b1;
        for (int i = 0; i < 60; i++)
            send_b($urandom_range(0, 255), ($urandom_range(0, 5) == 0));
        if (b_cnt != 0) send_b($urandom_range(0, 255), 1'b1);
        repeat (4) @(posedge clk);
        #1;

        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mac_accum_stage.md
# mac_accum_stage

Sequential accumulate stage directly downstream of the 4x4 array multiplier. It accepts 8-bit products over a valid/ready handshake and sums them into a wider accumulator. Each group of products closes on an explicit last flag or after a fixed beat count. The stage then holds the group result until the consumer takes it.

## Interface
- PROD_W, 8, product width; matches the multiplier output `o`.
- ACC_W, 16, accumulator width; must be ≥ PROD_W.
- MAX_BEATS, 4, maximum products per group; must be ≥ 1.
- CNT_W, $clog2(MAX_BEATS+1), width of the beat counter (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  product beat present.
- in_ready  out  1  stage can accept a beat.
- in_prod  in  PROD_W  unsigned product.
- in_last  in  1  this beat closes the group.
- out_valid  out  1  group result present.
- out_ready  in  1  consumer accepts the result.
- out_acc  out  ACC_W  group sum.
- out_count  out  CNT_W  number of beats in the group.
- out_ovf  out  1  sum exceeded 2^ACC_W−1 during the group.

## Operation
- States: IDLE (no beats yet), ACCUM (≥1 beat taken), HOLD (result presented).
- in_ready = (state != HOLD), combinational from state only.
- A beat is accepted when in_valid && in_ready.
  - acc ← acc + zero-extended in_prod (from 0 in IDLE).
  - count ← count + 1.
  - ovf is sticky-ORed with the adder carry-out.
- Group close: accepted beat with in_last = 1, or the accepted beat that makes count == MAX_BEATS. Either one moves the stage to HOLD.
- Otherwise an accepted beat moves IDLE→ACCUM and leaves ACCUM in ACCUM.
- HOLD: out_valid = 1. out_acc, out_count and out_ovf are stable until out_valid && out_ready. On that handshake: next state IDLE; acc, count and ovf clear to 0.
- In IDLE/ACCUM, out_valid = 0 and out_acc/out_count/out_ovf show the running values.
- A zero product is a valid beat and is counted.
- in_last on a beat that also reaches MAX_BEATS closes the group once.
- in_prod and in_last are ignored when no beat is accepted.
- Reset: state IDLE, acc 0, count 0, ovf 0. Outputs after reset: in_ready 1, out_valid 0, out_acc 0, out_count 0, out_ovf 0. A partial group is discarded.

## Timing
- A closing beat accepted at edge t gives out_valid = 1 from t+1.
- A result handshake at edge t gives in_ready = 1 from t+1. There is no same-cycle bypass from HOLD to accepting a new beat.
- Throughput: one beat per cycle within a group. There is one bubble cycle minimum per group (the HOLD cycle).
- Each addition is single-cycle, registered; there is no internal pipelining.
- Assertion of rst_n takes effect immediately. Deassertion is synchronous to clk by the system reset synchroniser.

## Configuration
- MAC_ACC_SAT_EN defined: on a carry-out, acc saturates to 2^ACC_W−1 and stays there for the rest of the group; out_ovf = 1.
- MAC_ACC_SAT_EN undefined: acc wraps modulo 2^ACC_W; out_ovf still records the carry-out.

## Structure
- Package mac_acc_pkg holds:
  - state enum (IDLE, ACCUM, HOLD);
  - default parameter constants;
  - a localparam for the saturation value.
- One sub-module, accum_add: ACC_W-bit adder of acc and zero-extended product, giving sum and carry-out. It is combinational and instantiated once.
- The FSM and registers live in mac_accum_stage.

## Test plan
- Four beats of 225, in_last = 0, defaults → out_acc = 900, out_count = 4, out_ovf = 0, out_valid on the cycle after the 4th beat.
- Beats 10 then 20 with in_last on 20 → out_acc = 30, out_count = 2; in_ready = 0 while out_valid = 1.
- Backpressure: result pending with out_ready = 0 for 5 cycles → out_valid stays 1, outputs stable, in_valid beats are not accepted; release → in_ready = 1 the next cycle.
- Overflow with ACC_W = 10, MAX_BEATS = 8, eight beats of 225:
  - without MAC_ACC_SAT_EN → out_acc = 776, out_ovf = 1;
  - with MAC_ACC_SAT_EN → out_acc = 1023, out_ovf = 1.
- Reset mid-group after beats 5, 7 → all outputs 0 immediately; a next group of a single beat 3 with in_last → out_acc = 3, out_count = 1.
- A single beat of 0 with in_last → out_acc = 0, out_count = 1, out_valid = 1.
